dbg_frame_encoder: RTL
======================

# dbg_frame_encoder

Synthesizable encoder that turns word-level debug-bus requests into the byte-serial command frames consumed by the UART debug bridge: command byte, length byte, big-endian address, then little-endian write data. It sits in front of the TX byte FIFO feeding `dbg_bridge_uart`. It replaces hand-built byte arrays with a parametrised request/stream interface that supports write and read frames, back-pressure on both sides, and oversize-request splitting.

## Interface
- `ADDR_W`, 32, address width; multiple of 8, range 8..32; address field is `ADDR_W/8` bytes.
- `MAX_WORDS`, 63, maximum words per frame; `4*MAX_WORDS` must be ≤ 255.
- `CNT_W`, 16, width of `req_words_i`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_write_i`  in  1  1 = write frame (0x10), 0 = read frame (0x11).
- `req_addr_i`  in  ADDR_W  start byte address.
- `req_words_i`  in  CNT_W  number of 32-bit words.
- `wdata_valid_i`  in  1  write-data word valid.
- `wdata_i`  in  32  write-data word.
- `wdata_ready_o`  out  1  write word consumed when high with `wdata_valid_i`.
- `tx_valid_o`  out  1  byte valid toward the FIFO.
- `tx_data_o`  out  8  frame byte.
- `tx_accept_i`  in  1  FIFO accepts the byte (FIFO `accept_o`).
- `busy_o`  out  1  a frame is in progress.
- `err_o`  out  1  one-cycle pulse on a rejected request.

## Operation
- States: IDLE, CMD, LEN, ADDR, DATA.
- IDLE:
  - `req_ready_o`=1.
  - On handshake, latch write flag, address and word count.
  - If words==0, or words>MAX_WORDS without split support, pulse `err_o`, emit no bytes and stay in IDLE.
- CMD emits 0x10 or 0x11.
- LEN emits `4*min(words_left, MAX_WORDS)`, 8-bit.
- ADDR emits the address MSB first, `ADDR_W/8` bytes; a 2-bit (or wider) index counts down.
- DATA (write frames only):
  - A 32-bit holding register is loaded via the wdata handshake.
  - Bytes are emitted [7:0], [15:8], [23:16], [31:24].
  - A word counter decrements after byte 3 is accepted.
- Read frames go from ADDR directly to frame end.
- Frame end:
  - If words remain, start a new frame at CMD with address += `4*MAX_WORDS`; the sum wraps modulo 2^ADDR_W.
  - Otherwise return to IDLE.
- A byte advances only when `tx_valid_o && tx_accept_i`.
- `tx_data_o` and `tx_valid_o` are held stable while not accepted.
- `wdata_ready_o`=1 in DATA when the holding register is empty, or when byte 3 is being accepted that cycle (combinational from `tx_accept_i`).
- In DATA with an empty holding register and no `wdata_valid_i`: `tx_valid_o`=0, state held.
- `wdata_i` is ignored outside DATA. Extra words beyond the count are not consumed.

## Timing
- Reset values:
  - `req_ready_o`=1, `tx_valid_o`=0, `tx_data_o`=0x00.
  - `wdata_ready_o`=0, `busy_o`=0, `err_o`=0.
  - State IDLE, all counters 0.
- Request handshake at cycle N → cmd byte valid at N+1.
- With continuous accept and data: one byte per cycle, no bubble between words or between split frames.
- Write frame length is `2 + ADDR_W/8 + 4*words` cycles.
- `busy_o`=1 from N+1 until the cycle after the last byte is accepted. `req_ready_o`=!busy_o, so there are no back-to-back accepts within a frame.
- `err_o` is asserted at N+1 for exactly one cycle.
- Reset mid-frame aborts immediately. The partial frame is not completed and the next request after release starts at CMD.

## Configuration
- `DBG_FRAME_ENC_SPLIT_EN` defined: requests with words>MAX_WORDS are split into ⌈words/MAX_WORDS⌉ consecutive frames, each with its own cmd/len/address header.
- Undefined: such requests are rejected with `err_o` and no bytes, and the split address adder is not built.

## Structure
- Package `dbg_frame_pkg` holds:
  - `CMD_WRITE`=8'h10, `CMD_READ`=8'h11.
  - The state enum `dbg_frame_state_t`.
  - A function computing the length byte.
- Sub-module `dbg_frame_ser`: 32-bit holding register plus byte index with the valid/accept handshake, giving word-in/byte-out.
- Top: FSM, counters, header muxing.

## Test plan
- Write 1 word 0xDEADBEEF to 0x00001000, accept tied high → bytes 10 04 00 00 10 00 EF BE AD DE on 10 consecutive cycles; `busy_o` then drops.
- Write 5 words {0,0x100,17,1,1} to 0xF0000000 → header 10 14 F0 00 00 00, then data 00 00 00 00 00 01 00 00 11 00 00 00 01 00 00 00 01 00 00 00.
- Read 2 words at 0x20000004 → 11 08 20 00 00 04; `wdata_ready_o` never asserted.
- Random `tx_accept_i` (50 %) and `wdata_valid_i` gaps → byte sequence identical to the unstalled run; `tx_data_o` stable during every stall.
- words=0 → single `err_o` pulse, no `tx_valid_o`. With split enabled, MAX_WORDS=4 and words=6 at 0x100 → frames (10 10 …0100, 4 words) then (10 08 …0110, 2 words).
- Assert `rst_i` low during the ADDR bytes → `tx_valid_o`=0 immediately. After release, a new 1-word write emits a clean full frame.

Source files
------------

// File: rtl/dbg_frame_pkg.sv
// Shared constants, FSM state type and length-byte helper for the debug-bridge frame encoder.
package dbg_frame_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h10;
    localparam logic [7:0] CMD_READ  = 8'h11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_ADDR,
        ST_DATA
    } dbg_frame_state_t;

    // Payload length in bytes of the next frame: four bytes per word, capped at one frame.
    function automatic logic [7:0] len_byte(input logic [31:0] words_left,
                                            input logic [31:0] max_words);
        logic [31:0] n;
        n = (words_left > max_words) ? max_words : words_left;
        return 8'(n << 2);
    endfunction

endpackage

// File: rtl/dbg_frame_ser.sv
// Word-in / byte-out serializer: 32-bit holding register emitted LSB byte first.
module dbg_frame_ser (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        more_i,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    output logic        word_ready_o,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    input  logic        byte_accept_i,
    output logic        last_accept_o
);

    logic [31:0] word_q;
    logic        full_q;
    logic [1:0]  idx_q;
    logic        fire;
    logic        load;

    // An empty register passes the incoming word's low byte straight through,
    // so the first data byte follows the header without a bubble.
    assign byte_valid_o  = full_q || (enable_i && word_valid_i);
    assign byte_o        = full_q ? 8'(word_q >> {idx_q, 3'b000}) : word_i[7:0];
    assign fire          = enable_i && byte_valid_o && byte_accept_i;
    assign last_accept_o = fire && full_q && (idx_q == 2'd3);
    assign word_ready_o  = enable_i && (!full_q || (last_accept_o && more_i));
    assign load          = word_ready_o && word_valid_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            word_q <= 32'h0;
            full_q <= 1'b0;
            idx_q  <= 2'd0;
        end else if (load) begin
            word_q <= word_i;
            full_q <= 1'b1;
            idx_q  <= (fire && !full_q) ? 2'd1 : 2'd0;
        end else if (fire) begin
            if (idx_q == 2'd3) begin
                full_q <= 1'b0;
                idx_q  <= 2'd0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/dbg_frame_encoder.sv
// Debug-bus request to UART bridge byte-frame encoder: cmd, len, BE address, LE write data.
// Define DBG_FRAME_ENC_SPLIT_EN to split requests larger than MAX_WORDS into several frames.
module dbg_frame_encoder
    import dbg_frame_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 63,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [CNT_W-1:0]  req_words_i,
    input  logic              wdata_valid_i,
    input  logic [31:0]       wdata_i,
    output logic              wdata_ready_o,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_accept_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int               ADDR_BYTES = ADDR_W / 8;
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_WORDS);

    dbg_frame_state_t  state_q, state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  words_left_q;
    logic [7:0]        frame_left_q;
    logic [1:0]        addr_idx_q;
    logic              err_q;

    logic              req_fire, req_ok, tx_fire, addr_last, frame_done, more_frames;
    logic [CNT_W-1:0]  frame_words, words_after;
    logic              ser_valid, ser_last;
    logic [7:0]        ser_byte;

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = !req_ready_o;
    assign err_o       = err_q;
    assign req_fire    = req_valid_i && req_ready_o;
    assign tx_valid_o  = (state_q == ST_CMD) || (state_q == ST_LEN) || (state_q == ST_ADDR)
                      || ((state_q == ST_DATA) && ser_valid);
    assign tx_fire     = tx_valid_o && tx_accept_i;
    assign addr_last   = (addr_idx_q == 2'd0);
    assign frame_words = (words_left_q > MAX_CNT) ? MAX_CNT : words_left_q;

    // Read frames end on the last address byte; write frames on byte 3 of their last word.
    assign frame_done  = ((state_q == ST_ADDR) && tx_fire && addr_last && !write_q)
                      || ((state_q == ST_DATA) && ser_last && (frame_left_q == 8'd1));
    assign words_after = write_q ? (words_left_q - CNT_W'(1)) : (words_left_q - frame_words);

`ifdef DBG_FRAME_ENC_SPLIT_EN
    assign req_ok      = (req_words_i != '0);
    assign more_frames = (words_after != '0);
`else
    assign req_ok      = (req_words_i != '0) && (req_words_i <= MAX_CNT);
    assign more_frames = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_fire && req_ok) state_d = ST_CMD;
            ST_CMD:  if (tx_fire) state_d = ST_LEN;
            ST_LEN:  if (tx_fire) state_d = ST_ADDR;
            ST_ADDR: begin
                if (tx_fire && addr_last) begin
                    if (write_q)          state_d = ST_DATA;
                    else if (more_frames) state_d = ST_CMD;
                    else                  state_d = ST_IDLE;
                end
            end
            ST_DATA: if (frame_done) state_d = more_frames ? ST_CMD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data_o = 8'h00;
        case (state_q)
            ST_CMD:  tx_data_o = write_q ? CMD_WRITE : CMD_READ;
            ST_LEN:  tx_data_o = len_byte(32'(words_left_q), 32'(MAX_WORDS));
            ST_ADDR: tx_data_o = 8'(addr_q >> {addr_idx_q, 3'b000});
            ST_DATA: tx_data_o = ser_byte;
            default: tx_data_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            write_q      <= 1'b0;
            addr_q       <= '0;
            words_left_q <= '0;
            frame_left_q <= 8'd0;
            addr_idx_q   <= 2'd0;
            err_q        <= 1'b0;
        end else begin
            err_q <= req_fire && !req_ok;
            if (req_fire) begin
                write_q      <= req_write_i;
                addr_q       <= req_addr_i;
                words_left_q <= req_words_i;
            end
            if ((state_q == ST_CMD) && tx_fire)       addr_idx_q <= 2'(ADDR_BYTES - 1);
            else if ((state_q == ST_ADDR) && tx_fire) addr_idx_q <= addr_idx_q - 2'd1;
            if ((state_q == ST_LEN) && tx_fire) frame_left_q <= 8'(frame_words);
            else if (ser_last)                  frame_left_q <= frame_left_q - 8'd1;
            if (frame_done)    words_left_q <= words_after;
            else if (ser_last) words_left_q <= words_left_q - CNT_W'(1);
`ifdef DBG_FRAME_ENC_SPLIT_EN
            if (frame_done && more_frames) addr_q <= addr_q + ADDR_W'(4 * MAX_WORDS);
`endif
        end
    end

    dbg_frame_ser u_ser (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (state_q == ST_DATA),
        .more_i        (frame_left_q > 8'd1),
        .word_valid_i  (wdata_valid_i),
        .word_i        (wdata_i),
        .word_ready_o  (wdata_ready_o),
        .byte_valid_o  (ser_valid),
        .byte_o        (ser_byte),
        .byte_accept_i (tx_accept_i),
        .last_accept_o (ser_last)
    );

endmodule
